memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/memory_responder.sv
// Single-port word memory that answers read/write requests after a fixed latency.
// Handshake: accept in IDLE, count down in BUSY, pulse in RESPOND, wait in RELEASE for the request to drop.
module memory_responder #(
   parameter int LATENCY    = 2,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        readM,
   input  logic        writeM,
   input  logic [15:0] address,
   input  logic [15:0] data_in,
   output logic [15:0] data,
   output logic        inputReady,
   output logic        ackOutput
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY    = 2'd1;
   localparam logic [1:0] RESPOND = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]            state;
   logic [3:0]            count;
   logic                  is_read;
   logic [DEPTH_LOG2-1:0] addr_q;
   logic [15:0]           wdata_q;
   logic                  respond_now;

   // NOTE: the array is deliberately outside the reset domain; it starts zeroed and a reset must not clear it.
   logic [15:0] mem [2**DEPTH_LOG2] = '{default: 16'h0000};

   // Upper address bits alias onto the low ones.
   generate
      if (DEPTH_LOG2 < 16) begin : g_unused_addr
         logic unused_addr_bits;
         assign unused_addr_bits = ^address[15:DEPTH_LOG2];
      end
   endgenerate

   assign respond_now = (state == BUSY) && (count == 4'd0);

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= 4'd0;
         is_read    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 16'h0000;
         data       <= 16'h0000;
         inputReady <= 1'b0;
         ackOutput  <= 1'b0;
      end else begin
         inputReady <= 1'b0;
         ackOutput  <= 1'b0;
         case (state)
            IDLE: begin
               if (readM || writeM) begin
                  is_read <= readM;  // a read wins when both are asserted
                  addr_q  <= address[DEPTH_LOG2-1:0];
                  wdata_q <= data_in;
                  count   <= COUNT_LOAD;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else begin
                  state <= RESPOND;
                  if (is_read) begin
                     data       <= mem[addr_q];
                     inputReady <= 1'b1;
                  end else begin
                     ackOutput  <= 1'b1;
                  end
               end
            end
            RESPOND: state <= RELEASE;
            RELEASE: begin
               if (!readM && !writeM) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset forces state to IDLE asynchronously, so an aborted write never reaches this point.
   always_ff @(posedge clk) begin
      if (respond_now && !is_read) mem[addr_q] <= wdata_q;
   end

endmodule
